// File: rtl/hazard_ctrl_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_sb_pkg
// Description : Shared types and stage indices for the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_sb_pkg;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_DRAIN  = 2'd1,
        HZ_HALTED = 2'd2
    } hz_state_t;

    localparam int F2D = 0;
    localparam int D2E = 1;
    localparam int E2M = 2;
    localparam int M2W = 3;

    // Which RUN-mode priority rule won this cycle
    typedef enum logic [2:0] {
        RULE_MEM    = 3'd0,
        RULE_BRANCH = 3'd1,
        RULE_DSTALL = 3'd2,
        RULE_IMISS  = 3'd3,
        RULE_NONE   = 3'd4
    } run_rule_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Pending-register / busy-unit tracking for multi-cycle units.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_MC = 2,
    parameter int REG_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_MC-1:0]     issue,
    input  logic [NUM_MC-1:0]     mc_done,
    input  logic [REG_W-1:0]      id_rd,
    output logic [2**REG_W-1:0]   pend,
    output logic [NUM_MC-1:0]     busy
);
    localparam int NREG = 2**REG_W;

    logic [NREG-1:0]   pend_q, pend_d;
    logic [NUM_MC-1:0] busy_q, busy_d;
    logic [REG_W-1:0]  tag_q [NUM_MC];
    logic [REG_W-1:0]  tag_d [NUM_MC];

    // Completions are applied first so a same-cycle issue to the same reg wins
    always_comb begin
        pend_d = pend_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int u = 0; u < NUM_MC; u++) begin
            if (mc_done[u] && busy_q[u]) begin
                busy_d[u]         = 1'b0;
                pend_d[tag_q[u]]  = 1'b0;
            end
        end
        for (int u = 0; u < NUM_MC; u++) begin
            if (issue[u]) begin
                busy_d[u] = 1'b1;
                tag_d[u]  = id_rd;
                if (id_rd != '0) begin
                    pend_d[id_rd] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            busy_q <= '0;
            for (int u = 0; u < NUM_MC; u++) begin
                tag_q[u] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    assign pend = pend_q;
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_sb.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_sb
// Description : Pipeline stall/flush control with MC scoreboard and halt drain.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_sb
    import hazard_ctrl_sb_pkg::*;
#(
    parameter int NUM_MC      = 2,
    parameter int REG_W       = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   dread,
    input  logic                   dwrite,
    input  logic                   branch_flush,
    input  logic                   ex_dread,
    input  logic [REG_W-1:0]       ex_rd,
    input  logic [REG_W-1:0]       id_rs1,
    input  logic [REG_W-1:0]       id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [REG_W-1:0]       id_rd,
    input  logic                   id_wen,
    input  logic [NUM_MC-1:0]      id_mc_req,
    input  logic [NUM_MC-1:0]      mc_done,
    output logic [3:0]             stage_en,
    output logic [3:0]             stage_flush,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    hz_state_t              state_q, state_d;
    logic [1:0]             drain_cnt_q, drain_cnt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic [2**REG_W-1:0]    w_pend;
    logic [NUM_MC-1:0]      w_busy;
    logic [NUM_MC-1:0]      w_issue;
    logic w_load_use, w_sb_raw, w_sb_waw, w_sb_struct, w_mem_stall, w_dstall;
    run_rule_t              w_rule;

    assign w_load_use  = ex_dread && (ex_rd != '0) &&
                         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign w_sb_raw    = (id_use_rs1 && (id_rs1 != '0) && w_pend[id_rs1]) ||
                         (id_use_rs2 && (id_rs2 != '0) && w_pend[id_rs2]);
    assign w_sb_waw    = id_wen && (id_rd != '0) && w_pend[id_rd];
    assign w_sb_struct = |(id_mc_req & w_busy & ~mc_done);
    assign w_mem_stall = (dread || dwrite) && !dhit;
    assign w_dstall    = w_load_use || w_sb_raw || w_sb_waw || w_sb_struct;

    always_comb begin
        if (w_mem_stall)       w_rule = RULE_MEM;
        else if (branch_flush) w_rule = RULE_BRANCH;
        else if (w_dstall)     w_rule = RULE_DSTALL;
        else if (!ihit)        w_rule = RULE_IMISS;
        else                   w_rule = RULE_NONE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HZ_RUN;
            drain_cnt_q <= 2'd0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_q     <= stall_d;
        end
    end

    // Next-state
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        stall_d     = stall_q;
        case (state_q)
            HZ_RUN: begin
                if (halt && (w_rule == RULE_IMISS || w_rule == RULE_NONE)) begin
                    state_d = HZ_DRAIN;
                end
                if (w_rule == RULE_DSTALL && !(&stall_q)) begin
                    stall_d = stall_q + 1'b1;
                end
            end
            HZ_DRAIN: begin
                if (!w_mem_stall && drain_cnt_q != 2'd3) begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
                if (drain_cnt_q == 2'd3 && w_pend == '0 && !(dread || dwrite)) begin
                    state_d = HZ_HALTED;
                end
            end
            default: state_d = HZ_HALTED;
        endcase
    end

    // Outputs, bits ordered {M2W,E2M,D2E,F2D}
    always_comb begin
        stage_en    = 4'b1111;
        stage_flush = 4'b0000;
        if (rst) begin
            stage_flush = 4'b1111;
        end else begin
            case (state_q)
                HZ_RUN: begin
                    case (w_rule)
                        RULE_MEM:    begin stage_en = 4'b1000; stage_flush = 4'b1000; end
                        RULE_BRANCH: stage_flush = 4'b0011;
                        RULE_DSTALL: begin stage_en = 4'b1110; stage_flush = 4'b0010; end
                        RULE_IMISS:  stage_flush = 4'b0001;
                        default:     stage_flush = 4'b0000;
                    endcase
                end
                HZ_DRAIN: begin
                    // E must not be overwritten with a bubble while M is frozen
                    if (w_mem_stall) begin
                        stage_en    = 4'b1001;
                        stage_flush = 4'b1001;
                    end else begin
                        stage_flush = 4'b0011;
                    end
                end
                default: begin
                    stage_en    = 4'b0000;
                    stage_flush = 4'b0000;
                end
            endcase
        end
    end

    assign w_issue      = id_mc_req & {NUM_MC{stage_en[D2E] & ~stage_flush[D2E]}};
    assign halted       = (state_q == HZ_HALTED);
    assign stall_cycles = stall_q;

    hazard_scoreboard #(
        .NUM_MC (NUM_MC),
        .REG_W  (REG_W)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .issue   (w_issue),
        .mc_done (mc_done),
        .id_rd   (id_rd),
        .pend    (w_pend),
        .busy    (w_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl_sb
// Description : Directed scoreboard bench for hazard_ctrl_sb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_sb;
    localparam int NUM_MC = 2;
    localparam int REG_W  = 5;
    localparam int SCW    = 16;

    logic clk = 1'b0;
    logic rst, halt, ihit, dhit, dread, dwrite, branch_flush, ex_dread;
    logic [REG_W-1:0] ex_rd, id_rs1, id_rs2, id_rd;
    logic id_use_rs1, id_use_rs2, id_wen;
    logic [NUM_MC-1:0] id_mc_req, mc_done;
    logic [3:0] stage_en, stage_flush;
    logic halted;
    logic [SCW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl_sb #(.NUM_MC(NUM_MC), .REG_W(REG_W), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst(rst), .halt(halt), .ihit(ihit), .dhit(dhit),
        .dread(dread), .dwrite(dwrite), .branch_flush(branch_flush),
        .ex_dread(ex_dread), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_wen(id_wen), .id_mc_req(id_mc_req), .mc_done(mc_done),
        .stage_en(stage_en), .stage_flush(stage_flush), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        string          name;
        logic [3:0]     en;
        logic [3:0]     fl;
        logic           h;
        logic [SCW-1:0] cnt;
        logic           full;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic chk      = 1'b0;

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per presented cycle
    always @(negedge clk) begin
        if (chk) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check_val({e.name, ".en"}, {28'd0, stage_en}, {28'd0, e.en});
                check_val({e.name, ".flush"}, {28'd0, stage_flush}, {28'd0, e.fl});
                if (e.full) begin
                    check_val({e.name, ".halted"}, {31'd0, halted}, {31'd0, e.h});
                    check_val({e.name, ".stall_cycles"}, {16'd0, stall_cycles}, {16'd0, e.cnt});
                end
            end
        end
    end

    task automatic idle();
        halt = 0; ihit = 1; dhit = 1; dread = 0; dwrite = 0; branch_flush = 0;
        ex_dread = 0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0;
        id_use_rs2 = 0; id_rd = '0; id_wen = 0; id_mc_req = '0; mc_done = '0;
    endtask

    task automatic cycle(input string nm, input logic [3:0] en, input logic [3:0] fl,
                         input logic h, input logic [SCW-1:0] cnt, input logic full);
        exp_t e;
        e.name = nm; e.en = en; e.fl = fl; e.h = h; e.cnt = cnt; e.full = full;
        q.push_back(e);
        chk = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        cycle("reset", 4'b1111, 4'b1111, 0, 0, 1);
        rst = 1'b0;

        // 1: load-use
        idle(); ex_dread = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5;
        cycle("t1_load_use", 4'b1110, 4'b0010, 0, 0, 1);
        idle();
        cycle("t1_release", 4'b1111, 4'b0000, 0, 1, 1);
        idle(); ex_dread = 1; ex_rd = 0; id_use_rs2 = 1; id_rs2 = 0;
        cycle("t1_x0_no_stall", 4'b1111, 4'b0000, 0, 1, 1);

        // 2: mult RAW on x7, done on the 4th held cycle
        idle(); id_mc_req = 2'b01; id_wen = 1; id_rd = 7;
        cycle("t2_issue", 4'b1111, 4'b0000, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            idle(); id_use_rs1 = 1; id_rs1 = 7; mc_done = (i == 3) ? 2'b01 : 2'b00;
            cycle("t2_raw_hold", 4'b1110, 4'b0010, 0, SCW'(1 + i), 1);
        end
        idle(); id_use_rs1 = 1; id_rs1 = 7;
        cycle("t2_release", 4'b1111, 4'b0000, 0, 5, 1);
        idle(); id_mc_req = 2'b10; id_wen = 1; id_rd = 0;
        cycle("t2_x0_issue", 4'b1111, 4'b0000, 0, 5, 1);
        idle(); id_use_rs2 = 1; id_rs2 = 0; id_wen = 1; id_rd = 0; mc_done = 2'b10;
        cycle("t2_x0_no_raw", 4'b1111, 4'b0000, 0, 5, 1);

        // 3: mem stall beats branch flush, then branch beats dstall
        for (int i = 0; i < 2; i++) begin
            idle(); dread = 1; dhit = 0; branch_flush = 1;
            cycle("t3_mem_stall", 4'b1000, 4'b1000, 0, 5, 1);
        end
        idle(); dread = 1; branch_flush = 1; ex_dread = 1; ex_rd = 6; id_use_rs1 = 1; id_rs1 = 6;
        cycle("t3_branch", 4'b1111, 4'b0011, 0, 5, 1);
        idle(); ihit = 0;
        cycle("t3_imiss", 4'b1111, 4'b0001, 0, 5, 1);

        // 4: structural hazard and same-cycle done+issue
        idle(); id_mc_req = 2'b01; id_wen = 1; id_rd = 8;
        cycle("t4_issue", 4'b1111, 4'b0000, 0, 5, 1);
        idle(); id_mc_req = 2'b01; id_wen = 1; id_rd = 9;
        cycle("t4_struct", 4'b1110, 4'b0010, 0, 5, 1);
        idle(); id_mc_req = 2'b01; id_wen = 1; id_rd = 9; mc_done = 2'b01;
        cycle("t4_done_issue", 4'b1111, 4'b0000, 0, 6, 1);
        idle(); id_mc_req = 2'b01; id_wen = 1; id_rd = 10;
        cycle("t4_busy_kept", 4'b1110, 4'b0010, 0, 6, 1);
        idle(); id_wen = 1; id_rd = 9;
        cycle("t4_waw", 4'b1110, 4'b0010, 0, 7, 1);
        idle(); mc_done = 2'b01;
        cycle("t4_done", 4'b1111, 4'b0000, 0, 8, 1);
        idle(); mc_done = 2'b01; id_use_rs1 = 1; id_rs1 = 9;
        cycle("t4_released", 4'b1111, 4'b0000, 0, 8, 1);

        // 5: halt with div to x3 outstanding, done 6 cycles after issue
        idle(); id_mc_req = 2'b10; id_wen = 1; id_rd = 3;
        cycle("t5_issue", 4'b1111, 4'b0000, 0, 8, 1);
        idle(); halt = 1;
        cycle("t5_halt", 4'b1111, 4'b0000, 0, 8, 1);
        for (int i = 0; i < 6; i++) begin
            idle(); mc_done = (i == 4) ? 2'b10 : 2'b00;
            cycle("t5_drain", 4'b1111, 4'b0011, 0, 8, 1);
        end
        idle();
        cycle("t5_halted", 4'b0000, 4'b0000, 1, 8, 1);
        idle(); ex_dread = 1; ex_rd = 1; id_use_rs1 = 1; id_rs1 = 1; branch_flush = 1;
        cycle("t5_halted_sticky", 4'b0000, 4'b0000, 1, 8, 1);

        // 6: reset out of HALTED, then reset in DRAIN with pending entry
        rst = 1'b1; idle();
        cycle("t6_rst_halted", 4'b1111, 4'b1111, 0, 0, 0);
        rst = 1'b0;
        idle();
        cycle("t6_after_rst", 4'b1111, 4'b0000, 0, 0, 1);
        idle(); id_mc_req = 2'b01; id_wen = 1; id_rd = 4;
        cycle("t6_issue", 4'b1111, 4'b0000, 0, 0, 1);
        idle(); halt = 1;
        cycle("t6_halt", 4'b1111, 4'b0000, 0, 0, 1);
        idle();
        cycle("t6_drain", 4'b1111, 4'b0011, 0, 0, 1);
        rst = 1'b1; idle();
        cycle("t6_rst_drain", 4'b1111, 4'b1111, 0, 0, 0);
        rst = 1'b0;
        idle(); id_use_rs1 = 1; id_rs1 = 4;
        cycle("t6_pend_cleared", 4'b1111, 4'b0000, 0, 0, 1);
        idle(); ex_dread = 1; ex_rd = 2; id_use_rs2 = 1; id_rs2 = 2;
        cycle("t6_run_rules", 4'b1110, 4'b0010, 0, 0, 1);
        idle();
        cycle("t6_cnt", 4'b1111, 4'b0000, 0, 1, 1);

        chk = 1'b0;
        check_val("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
